// File: rtl/i2c_master_seq_if.sv
// ---------------------------------------------------------------------------
// i2c_master_seq_if
// Host-side request/response bundle for the I2C master sequencer.
//   req    : start a transaction (sampled only while the sequencer is idle)
//   rw     : 0 = write, 1 = read
//   addr   : 7-bit slave address
//   wdata  : byte to write
//   busy   : transaction in flight
//   done   : one-cycle completion pulse
//   nack   : address or write-data NACK, valid with done
//   rdata  : byte read, updated at done of a successful read
// modport master = requester, modport slave = sequencer.
// ---------------------------------------------------------------------------
interface i2c_master_seq_if;
    logic       req;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       nack;
    logic [7:0] rdata;

    modport master (
        output req, rw, addr, wdata,
        input  busy, done, nack, rdata
    );

    modport slave (
        input  req, rw, addr, wdata,
        output busy, done, nack, rdata
    );
endinterface

// File: rtl/i2c_master_seq.sv
// ---------------------------------------------------------------------------
// i2c_master_seq
// Single-transaction I2C master sequencer in front of an SCL clock generator.
// Generates START, address + R/W, one data byte, ACK/NACK and STOP on the
// open-drain SDA line, pulsing start_cond/stop_cond to the generator and
// following the bus SCL it produces.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   host            : request/response bundle (i2c_master_seq_if.slave)
//   scl_in          : bus SCL from the pin (asynchronous)
//   sda_t           : open-drain SDA (z = released, 0 = driven)
//   start_cond      : one-cycle pulse to the clock generator
//   stop_cond       : one-cycle pulse to the clock generator
// ---------------------------------------------------------------------------
module i2c_master_seq #(
    parameter int unsigned START_HOLD = 4,
    parameter int unsigned STOP_HOLD  = 4
) (
    input  logic               clk,
    input  logic               reset,
    i2c_master_seq_if.slave    host,
    input  logic               scl_in,
    inout  wire                sda_t,
    output logic               start_cond,
    output logic               stop_cond
);

    localparam int unsigned HOLD_MAX = (START_HOLD > STOP_HOLD) ? START_HOLD : STOP_HOLD;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_STOP_LOW,
        S_STOP_HIGH,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                rw_q, rw_d;
    logic [7:0]          rdata_sh_q, rdata_sh_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                bit_last_q, bit_last_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                started_q, started_d;
    logic                addr_nack_q, addr_nack_d;
    logic                nack_flag_q, nack_flag_d;
    logic                sda_oe_q, sda_oe_d;
    logic                start_cond_q, start_cond_d;
    logic                stop_cond_q, stop_cond_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                nack_q, nack_d;
    logic [7:0]          rdata_q, rdata_d;

    // two-flop synchronisers for the bus lines, plus SCL history for edges
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q;
    logic scl_rise, scl_fall;

    assign scl_rise = scl_sync_q & ~scl_prev_q;
    assign scl_fall = ~scl_sync_q & scl_prev_q;

    assign sda_t       = sda_oe_q ? 1'b0 : 1'bz;
    assign start_cond  = start_cond_q;
    assign stop_cond   = stop_cond_q;
    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.nack   = nack_q;
    assign host.rdata  = rdata_q;

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            rdata_sh_q   <= '0;
            bit_cnt_q    <= '0;
            bit_last_q   <= 1'b0;
            hold_cnt_q   <= '0;
            started_q    <= 1'b0;
            addr_nack_q  <= 1'b0;
            nack_flag_q  <= 1'b0;
            sda_oe_q     <= 1'b0;
            start_cond_q <= 1'b0;
            stop_cond_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            nack_q       <= 1'b0;
            rdata_q      <= '0;
            scl_meta_q   <= 1'b0;
            scl_sync_q   <= 1'b0;
            scl_prev_q   <= 1'b0;
            sda_meta_q   <= 1'b1;
            sda_sync_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            rdata_sh_q   <= rdata_sh_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_last_q   <= bit_last_d;
            hold_cnt_q   <= hold_cnt_d;
            started_q    <= started_d;
            addr_nack_q  <= addr_nack_d;
            nack_flag_q  <= nack_flag_d;
            sda_oe_q     <= sda_oe_d;
            start_cond_q <= start_cond_d;
            stop_cond_q  <= stop_cond_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            nack_q       <= nack_d;
            rdata_q      <= rdata_d;
            scl_meta_q   <= scl_in;
            scl_sync_q   <= scl_meta_q;
            scl_prev_q   <= scl_sync_q;
            sda_meta_q   <= sda_t;
            sda_sync_q   <= sda_meta_q;
        end
    end

    // next-state and output logic
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        rdata_sh_d   = rdata_sh_q;
        bit_cnt_d    = bit_cnt_q;
        bit_last_d   = bit_last_q;
        hold_cnt_d   = hold_cnt_q;
        started_d    = started_q;
        addr_nack_d  = addr_nack_q;
        nack_flag_d  = nack_flag_q;
        sda_oe_d     = sda_oe_q;
        start_cond_d = 1'b0;
        stop_cond_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        nack_d       = nack_q;
        rdata_d      = rdata_q;

        case (state_q)
            // accept only when the bus SCL is idle-high
            S_IDLE: begin
                if (host.req && scl_sync_q) begin
                    shift_d     = {host.addr, host.rw};
                    rw_d        = host.rw;
                    wdata_d     = host.wdata;
                    rdata_sh_d  = '0;
                    hold_cnt_d  = '0;
                    started_d   = 1'b0;
                    addr_nack_d = 1'b0;
                    nack_flag_d = 1'b0;
                    nack_d      = 1'b0;
                    busy_d      = 1'b1;
                    sda_oe_d    = 1'b1;
                    state_d     = S_START;
                end
            end

            // SDA already low; hand SCL to the generator after the hold
            S_START: begin
                if (!started_q) begin
                    if (hold_cnt_q == HOLD_W'(START_HOLD - 1)) begin
                        start_cond_d = 1'b1;
                        started_d    = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else if (scl_fall) begin
                    sda_oe_d   = ~shift_q[7];
                    shift_d    = {shift_q[6:0], 1'b0};
                    bit_cnt_d  = '0;
                    bit_last_d = 1'b0;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR: begin
                if (scl_rise) begin
                    if (bit_cnt_q == 3'd7) bit_last_d = 1'b1;
                    else                   bit_cnt_d  = bit_cnt_q + 3'd1;
                end
                if (scl_fall) begin
                    if (bit_last_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_ADDR_ACK;
                    end else begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end
            end

            S_ADDR_ACK: begin
                if (scl_rise) begin
                    addr_nack_d = sda_sync_q;
                    nack_flag_d = sda_sync_q;
                end
                if (scl_fall) begin
                    if (addr_nack_q) begin
                        state_d = S_STOP_LOW;
                    end else begin
                        bit_cnt_d  = '0;
                        bit_last_d = 1'b0;
                        state_d    = S_DATA;
                        if (!rw_q) begin
                            sda_oe_d = ~wdata_q[7];
                            shift_d  = {wdata_q[6:0], 1'b0};
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
            end

            S_DATA: begin
                if (scl_rise) begin
                    if (bit_cnt_q == 3'd7) bit_last_d = 1'b1;
                    else                   bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (rw_q) rdata_sh_d = {rdata_sh_q[6:0], sda_sync_q};
                end
                if (scl_fall) begin
                    if (bit_last_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_DATA_ACK;
                    end else if (!rw_q) begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end
            end

            // write: sample slave ACK; read: SDA stays released as master NACK
            S_DATA_ACK: begin
                if (scl_rise && !rw_q) nack_flag_d = sda_sync_q;
                if (scl_fall)          state_d     = S_STOP_LOW;
            end

            S_STOP_LOW: begin
                sda_oe_d    = 1'b1;
                stop_cond_d = 1'b1;
                hold_cnt_d  = '0;
                state_d     = S_STOP_HIGH;
            end

            // release SDA only after SCL has been high long enough
            S_STOP_HIGH: begin
                if (!scl_sync_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_W'(STOP_HOLD - 1)) begin
                    sda_oe_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    nack_d   = nack_flag_q;
                    if (rw_q && !addr_nack_q) rdata_d = rdata_sh_q;
                    state_d  = S_DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_seq
// Bench for i2c_master_seq: an SCL generator model, a bus monitor that
// records SDA at each SCL rise and detects START/STOP, and a slave model
// that ACKs and returns read data. Transactions come from a vector table;
// corner cases (SCL held low, mid-transfer reset, back-to-back) are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_i2c_master_seq;

    localparam int unsigned START_HOLD = 4;
    localparam int unsigned STOP_HOLD  = 4;
    localparam int unsigned HALF       = 8;
    localparam int unsigned NVEC       = 6;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       sl_aack;
        logic       sl_dack;
        logic [7:0] sl_rdata;
        logic [7:0] exp_abyte;
        logic       exp_abit9;
        logic [7:0] exp_dbyte;
        logic       exp_dbit9;
        int         exp_rises;
        logic       exp_nack;
        logic [7:0] exp_rdata;
    } vec_t;

    logic clk;
    logic reset;
    logic scl_gen;
    logic scl_hold_low;
    logic scl_in;
    wire  sda;
    logic start_cond;
    logic stop_cond;

    i2c_master_seq_if hif ();

    i2c_master_seq #(
        .START_HOLD (START_HOLD),
        .STOP_HOLD  (STOP_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (hif.slave),
        .scl_in     (scl_in),
        .sda_t      (sda),
        .start_cond (start_cond),
        .stop_cond  (stop_cond)
    );

    pullup (sda);

    logic sl_drive;
    logic sl_aack;
    logic sl_dack;
    logic [7:0] sl_rdata;
    assign sda    = sl_drive ? 1'b0 : 1'bz;
    assign scl_in = scl_gen & ~scl_hold_low;

    int n_vec;
    int n_bad;
    int n_start;
    int n_stop;
    int n_overlap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SCL generator model: toggles after start_cond, parks high after stop_cond
    logic        gen_on;
    logic        gen_stop;
    int unsigned gen_cnt;
    always @(posedge clk) begin
        if (!reset) begin
            gen_on   <= 1'b0;
            gen_stop <= 1'b0;
            gen_cnt  <= 0;
            scl_gen  <= 1'b1;
        end else begin
            if (start_cond) begin
                gen_on  <= 1'b1;
                gen_cnt <= 0;
            end
            if (stop_cond) gen_stop <= 1'b1;
            if (gen_on) begin
                if (gen_cnt == HALF - 1) begin
                    gen_cnt <= 0;
                    if ((gen_stop || stop_cond) && !scl_gen) begin
                        scl_gen  <= 1'b1;
                        gen_on   <= 1'b0;
                        gen_stop <= 1'b0;
                    end else if (!(gen_stop || stop_cond)) begin
                        scl_gen <= ~scl_gen;
                    end
                end else begin
                    gen_cnt <= gen_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (start_cond) n_start <= n_start + 1;
        if (stop_cond)  n_stop  <= n_stop + 1;
        if (start_cond && stop_cond) n_overlap <= n_overlap + 1;
    end

    // bus monitor and slave
    logic scl_m, sda_m, in_xfer;
    logic bus_bits [0:31];
    int   rise_cnt;
    int   last_rises;
    int   high_cnt;
    int   stop_high;

    function automatic logic slave_low(input int nb);
        if (nb == 9) return sl_aack;
        if (!sl_aack) return 1'b0;
        if (bus_bits[7] == 1'b0) return (nb == 18) && sl_dack;
        if (nb >= 10 && nb <= 17) return !sl_rdata[3'(17 - nb)];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            scl_m    <= 1'b1;
            sda_m    <= 1'b1;
            in_xfer  <= 1'b0;
            rise_cnt <= 0;
            high_cnt <= 0;
            sl_drive <= 1'b0;
        end else begin
            scl_m <= scl_in;
            sda_m <= sda;
            if (scl_in) high_cnt <= high_cnt + 1;
            else        high_cnt <= 0;
            if (scl_in && scl_m && sda_m && !sda) begin
                in_xfer  <= 1'b1;
                rise_cnt <= 0;
            end else if (scl_in && scl_m && !sda_m && sda) begin
                in_xfer    <= 1'b0;
                last_rises <= rise_cnt;
                stop_high  <= high_cnt;
                sl_drive   <= 1'b0;
            end
            if (in_xfer && scl_in && !scl_m) begin
                if (rise_cnt < 32) bus_bits[rise_cnt] <= sda;
                rise_cnt <= rise_cnt + 1;
            end
            if (in_xfer && !scl_in && scl_m) sl_drive <= slave_low(rise_cnt + 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (hif.done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] bus_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = bus_bits[base + i];
        return b;
    endfunction

    function automatic vec_t mk(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                                input logic aack, input logic dack, input logic [7:0] srd,
                                input logic [7:0] abyte, input logic abit9,
                                input logic [7:0] dbyte, input logic dbit9,
                                input int rises, input logic nack, input logic [7:0] rdata);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wdata = wdata;
        v.sl_aack = aack; v.sl_dack = dack; v.sl_rdata = srd;
        v.exp_abyte = abyte; v.exp_abit9 = abit9;
        v.exp_dbyte = dbyte; v.exp_dbit9 = dbit9;
        v.exp_rises = rises; v.exp_nack = nack; v.exp_rdata = rdata;
        return v;
    endfunction

    // one full transaction from the table; entered #1 after a clock edge
    task automatic run_xfer(input vec_t v, input string tag);
        int s0, p0;
        bit got;
        sl_aack  = v.sl_aack;
        sl_dack  = v.sl_dack;
        sl_rdata = v.sl_rdata;
        s0 = n_start;
        p0 = n_stop;
        hif.rw    = v.rw;
        hif.addr  = v.addr;
        hif.wdata = v.wdata;
        hif.req   = 1'b1;
        @(posedge clk); #1;
        hif.req = 1'b0;
        check({tag, "_busy"}, 32'(hif.busy), 32'd1);
        check({tag, "_nack_clr"}, 32'(hif.nack), 32'd0);
        wait_done(got);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_busy_at_done"}, 32'(hif.busy), 32'd0);
        check({tag, "_nack"}, 32'(hif.nack), 32'(v.exp_nack));
        check({tag, "_rdata"}, 32'(hif.rdata), 32'(v.exp_rdata));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(hif.done), 32'd0);
        // the last recorded rise is the STOP rise, not a data bit
        check({tag, "_rises"}, 32'(last_rises - 1), 32'(v.exp_rises));
        check({tag, "_abyte"}, 32'(bus_byte(0)), 32'(v.exp_abyte));
        check({tag, "_abit9"}, 32'(bus_bits[8]), 32'(v.exp_abit9));
        if (v.exp_rises == 18) begin
            check({tag, "_dbyte"}, 32'(bus_byte(9)), 32'(v.exp_dbyte));
            check({tag, "_dbit9"}, 32'(bus_bits[17]), 32'(v.exp_dbit9));
        end
        check({tag, "_start_pulses"}, 32'(n_start - s0), 32'd1);
        check({tag, "_stop_pulses"}, 32'(n_stop - p0), 32'd1);
    endtask

    vec_t vecs [NVEC];

    initial begin
        vec_t v;
        bit   got;
        int   s0;
        int   n;

        n_vec = 0; n_bad = 0;
        n_start = 0; n_stop = 0; n_overlap = 0;
        stop_high = 0; last_rises = 0;
        sl_aack = 1'b1; sl_dack = 1'b1; sl_rdata = 8'h00;
        scl_hold_low = 1'b0;
        hif.req = 1'b0; hif.rw = 1'b0; hif.addr = '0; hif.wdata = '0;
        reset = 1'b0;

        //        rw    addr   wdata  aack  dack  srd    abyte abit9 dbyte dbit9 rises nack  rdata
        vecs[0] = mk(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 8'hA0, 1'b0, 8'hA5, 1'b0, 18, 1'b0, 8'h00);
        vecs[1] = mk(1'b1, 7'h3C, 8'h00, 1'b1, 1'b1, 8'h96, 8'h79, 1'b0, 8'h96, 1'b1, 18, 1'b0, 8'h96);
        vecs[2] = mk(1'b0, 7'h12, 8'h00, 1'b0, 1'b1, 8'h00, 8'h24, 1'b1, 8'h00, 1'b0,  9, 1'b1, 8'h96);
        vecs[3] = mk(1'b0, 7'h7F, 8'h3C, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 8'h3C, 1'b1, 18, 1'b1, 8'h96);
        vecs[4] = mk(1'b1, 7'h01, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h03, 1'b1, 8'h00, 1'b0,  9, 1'b1, 8'h96);
        vecs[5] = mk(1'b1, 7'h7F, 8'h00, 1'b1, 1'b1, 8'h01, 8'hFF, 1'b0, 8'h01, 1'b1, 18, 1'b0, 8'h01);

        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", 32'(hif.busy), 32'd0);
        check("rst_done", 32'(hif.done), 32'd0);
        check("rst_nack", 32'(hif.nack), 32'd0);
        check("rst_rdata", 32'(hif.rdata), 32'd0);
        check("rst_start_cond", 32'(start_cond), 32'd0);
        check("rst_stop_cond", 32'(stop_cond), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_xfer(vecs[i], $sformatf("v%0d", i));
            repeat (4) @(posedge clk);
            #1;
        end

        // req is ignored while SCL is held low
        sl_aack = 1'b1; sl_dack = 1'b1;
        scl_hold_low = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        s0 = n_start;
        hif.rw = 1'b0; hif.addr = 7'h50; hif.wdata = 8'h11; hif.req = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("scl_low_busy", 32'(hif.busy), 32'd0);
        check("scl_low_no_start", 32'(n_start - s0), 32'd0);
        hif.req = 1'b0;
        scl_hold_low = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        hif.req = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                check("scl_rel_busy", 32'(hif.busy), 32'd1);
                hif.req = 1'b0;
            end
            if (start_cond) break;
        end
        check("scl_rel_start_latency", 32'(n), 32'(START_HOLD + 1));
        wait_done(got);
        check("scl_rel_done", 32'(got), 32'd1);
        check("scl_rel_nack", 32'(hif.nack), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // reset during data bit 4 of a write
        hif.rw = 1'b0; hif.addr = 7'h50; hif.wdata = 8'hA5; hif.req = 1'b1;
        @(posedge clk); #1;
        hif.req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (in_xfer && rise_cnt >= 13) begin
                got = 1'b1;
                break;
            end
        end
        check("midrst_reach_bit4", 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_sda", 32'(sda), 32'd1);
        check("midrst_busy", 32'(hif.busy), 32'd0);
        check("midrst_done", 32'(hif.done), 32'd0);
        check("midrst_start_cond", 32'(start_cond), 32'd0);
        check("midrst_stop_cond", 32'(stop_cond), 32'd0);
        check("midrst_rdata", 32'(hif.rdata), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        v = mk(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 8'hA0, 1'b0, 8'hA5, 1'b0, 18, 1'b0, 8'h00);
        run_xfer(v, "post_rst");
        repeat (4) @(posedge clk);
        #1;

        // back-to-back with req held high
        sl_aack = 1'b1; sl_dack = 1'b1;
        s0 = n_start;
        hif.rw = 1'b0; hif.addr = 7'h50; hif.wdata = 8'hA5; hif.req = 1'b1;
        @(posedge clk); #1;
        check("b2b_first_busy", 32'(hif.busy), 32'd1);
        wait_done(got);
        check("b2b_first_done", 32'(got), 32'd1);
        @(posedge clk); #1;
        check("b2b_gap_busy", 32'(hif.busy), 32'd0);
        check("b2b_gap_sda", 32'(sda), 32'd1);
        @(posedge clk); #1;
        check("b2b_accept", 32'(hif.busy), 32'd1);
        hif.req = 1'b0;
        check("b2b_stop_scl_high", 32'(stop_high >= int'(STOP_HOLD)), 32'd1);
        wait_done(got);
        check("b2b_second_done", 32'(got), 32'd1);
        check("b2b_second_nack", 32'(hif.nack), 32'd0);
        check("b2b_start_pulses", 32'(n_start - s0), 32'd2);
        repeat (4) @(posedge clk);
        #1;

        check("cond_overlap", 32'(n_overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Single-transaction I2C master sequencer that sits in front of the SCL clock generator.
- Issues start_cond/stop_cond pulses to the generator and watches the resulting bus SCL.
- Drives the open-drain SDA line: START, 7-bit address + R/W, slave ACK, one data byte (write or read), ACK/NACK, STOP.
- Reports completion and ACK status to the host-side requester.

Parameters:
- START_HOLD, 4: clk cycles SDA is held low with SCL high before start_cond is pulsed.
- STOP_HOLD, 4: clk cycles SCL must be high (synchronised) before SDA is released for STOP.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- req  input  1  start a transaction; sampled only in IDLE
- rw  input  1  0 = write, 1 = read; latched with req
- addr  input  7  slave address; latched with req
- wdata  input  8  write byte; latched with req
- scl_in  input  1  bus SCL as seen on the pin; asynchronous
- sda_t  inout  1  open-drain SDA: 1'bz when released, 0 when driven
- start_cond  output  1  one-cycle pulse to the clock generator
- stop_cond  output  1  one-cycle pulse to the clock generator
- busy  output  1  high from req acceptance until the done pulse
- done  output  1  one-cycle pulse at end of transaction
- nack  output  1  valid with done; 1 = address or write-data NACK
- rdata  output  8  read byte; updated at done of a read, held otherwise

Behaviour:
- Reset: all outputs 0 and SDA released (sda_t = z); state IDLE; rdata = 0. Reset mid-transaction aborts immediately, with no STOP generated.
- scl_in and sda_t readback each pass through a 2-flop synchroniser.
  - scl_rise/scl_fall are single-cycle edge flags taken from the synchronised SCL.
- SDA changes only in the cycle after scl_fall, except during START/STOP. SDA is sampled on scl_rise.

States:
- IDLE
  - req=1 and synced SCL=1: latch shift = {addr, rw}, latch wdata/rw, set busy=1, go to START.
  - req with synced SCL=0 is ignored (bus busy). req while busy is ignored.
- START
  - Drive SDA low and count START_HOLD cycles, then pulse start_cond for one cycle.
  - Wait for the first scl_fall, then go to ADDR.
- ADDR
  - On entry and on each scl_fall, present shift[7] (0 drives low, 1 releases), then shift left.
  - Bit counter 0..7 increments on scl_rise.
  - At the scl_fall following the 8th scl_rise, release SDA and go to ADDR_ACK.
- ADDR_ACK
  - Sample at scl_rise: 0 = ACK, 1 = NACK (sets nack).
  - At the next scl_fall: NACK goes to STOP_LOW; ACK goes to DATA.
- DATA
  - Write: shift out wdata MSB-first as in ADDR.
  - Read: keep SDA released; shift the sampled bit into rdata_sh LSB on each scl_rise.
  - After 8 bits, at scl_fall go to DATA_ACK.
- DATA_ACK
  - Write: release SDA, sample the slave ACK at scl_rise; NACK sets nack.
  - Read: master sends NACK (SDA released), no sample.
  - Next scl_fall goes to STOP_LOW.
- STOP_LOW
  - Drive SDA low while SCL is low and pulse stop_cond for one cycle; the generator then holds SCL high.
  - Go to STOP_HIGH.
- STOP_HIGH
  - Count STOP_HOLD consecutive cycles of synced SCL=1, then release SDA (STOP condition).
  - Go to DONE.
- DONE
  - done=1 for one cycle; nack valid.
  - If read and no address NACK: rdata <= rdata_sh.
  - busy=0 in the same cycle; return to IDLE. A new req is accepted the cycle after done.

Rules:
- nack is held from DONE until the next req acceptance, then cleared.
- start_cond and stop_cond never assert in the same cycle. Each asserts exactly once per completed transaction.
- The bit counter is 3 bits plus a terminal flag; no wrap beyond 8 bits.
- SCL stuck low in any waiting state leaves the block waiting (no timeout); only reset recovers.

Test Plan:
- Write 0x50/0xA5 with slave ACKing both bytes:
  - SDA bits seen at scl_rise are 1010000 0, ACK, then 10100101, ACK.
  - One start_cond and one stop_cond pulse; done with nack=0; 18 scl_rise total.
- Read 0x3C with the slave returning 0x96:
  - Address byte 0111100 1; master releases SDA on the 9th data-phase bit (NACK).
  - At done, rdata=0x96 and nack=0.
- Address NACK (SDA left high at the ACK bit):
  - No data bits are clocked; STOP is generated after the 9th bit.
  - done with nack=1; rdata unchanged from its previous value.
- req with scl_in held low: busy stays 0 and no start_cond is issued.
  - Release scl_in and re-assert req: the transaction starts START_HOLD+1 cycles later.
- Reset asserted in the middle of data bit 4:
  - Next cycle: sda_t=z, busy/done/start_cond/stop_cond=0.
  - After reset release, a new write completes normally.
- Back-to-back requests: req held high continuously.
  - Second transaction accepted exactly one cycle after the first done.
  - The second START is preceded by SDA release (STOP) with SCL high for ≥STOP_HOLD cycles.
